// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester owns a registered response slot that is returned with a valid/ready handshake.
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   output logic [31:0] alu_srca,
   output logic [31:0] alu_srcb,
   output logic [2:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zero,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zero
);

   logic last_grant;
   logic free0, free1;
   logic elig0, elig1;
   logic grant0, grant1;

   // A slot draining this cycle can be refilled in the same cycle.
   assign free0 = !rsp0_valid || rsp0_ready;
   assign free1 = !rsp1_valid || rsp1_ready;
   assign elig0 = req0_valid && free0;
   assign elig1 = req1_valid && free1;

   assign grant0 = elig0 && (!elig1 || last_grant);
   assign grant1 = elig1 && (!elig0 || !last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_srca = 32'b0;
      alu_srcb = 32'b0;
      alu_ctrl = 3'b000;
      if (grant0) begin
         alu_srca = req0_a;
         alu_srcb = req0_b;
         alu_ctrl = req0_op;
      end else if (grant1) begin
         alu_srca = req1_a;
         alu_srcb = req1_b;
         alu_ctrl = req1_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= 32'b0;
         rsp0_zero   <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= 32'b0;
         rsp1_zero   <= 1'b0;
         last_grant  <= 1'b1;
      end else begin
         if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
            last_grant  <= 1'b0;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
            last_grant  <= 1'b1;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single combinational ALU between two requesters (e.g. execute-stage datapath and a branch/compare unit). Each requester presents operands and a 3-bit ALU control code with a valid/ready handshake. The arbiter drives the ALU with the granted request, captures result and Zero into a per-requester response register, and returns them with a valid/ready handshake one cycle later.

## Interface
- No parameters; data width fixed at 32, control width fixed at 3.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  combinational grant; the operation is accepted in a cycle where valid && ready.
- req0_a, req0_b / req1_a, req1_b  in  32  operands (SrcA, SrcB).
- req0_op / req1_op  in  3  ALU control code: 000 AND, 001 OR, 010 ADD, 110 SUB; 011/100/101/111 yield 0.
- alu_srca, alu_srcb  out  32  to ALU SrcA/SrcB.
- alu_ctrl  out  3  to ALU control.
- alu_result  in  32  from ALU result (combinational in the same cycle).
- alu_zero  in  1  from ALU Zero.
- rsp0_valid / rsp1_valid  out  1  response held for requester N.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the response.
- rsp0_result / rsp1_result  out  32  registered ALU result.
- rsp0_zero / rsp1_zero  out  1  registered Zero flag.

## Operation
- Per-requester response slot: valid bit, 32-bit result, zero bit. Slot N is free when !rspN_valid, or when rspN_valid && rspN_ready (drained this cycle).
- Eligible N = reqN_valid && slot N free.
- Grant: only one eligible -> grant it. Both eligible -> grant the requester not granted most recently (last_grant pointer). None -> no grant.
- reqN_ready = grant to N; at most one ready high per cycle. Ready never asserted for an ineligible requester.
- On grant: alu_srca/alu_srcb/alu_ctrl = granted reqN_a/reqN_b/reqN_op. No grant: drive 32'b0, 32'b0, 3'b000.
- At the clock edge after a grant to N: rspN_result <= alu_result, rspN_zero <= alu_zero, rspN_valid <= 1, last_grant <= N.
- Slot drained without new grant: rspN_valid <= 0; result/zero hold last values.
- Drain and new grant to the same N in one cycle: slot refilled, rspN_valid stays 1 (back-to-back throughput 1 op/cycle/requester).
- Op codes are passed through unmodified; arbiter does no decode. Illegal codes return result 0, zero 1.
- Response fields must stay stable while rspN_valid && !rspN_ready.
- Requesters must hold reqN_a/b/op stable while valid && !ready (not checked).

## Timing
- Reset values: rsp0_valid=rsp1_valid=0, rsp*_result=0, rsp*_zero=0, last_grant=1 (so requester 0 wins the first conflict).
- reqN_ready and alu_* are combinational from req*_valid, rsp*_valid, rsp*_ready, last_grant; no combinational path from alu_result to any ready.
- Latency: accept in cycle T -> rspN_valid high in T+1.
- Sustained throughput: one ALU op per cycle total; with both requesters continuously valid and responses always drained, grants alternate 0,1,0,1...
- Back-pressure: rspN_valid && !rspN_ready blocks requester N only; other requester may take every cycle.
- Reset mid-operation: reset in any cycle clears all response slots and last_grant regardless of concurrent handshakes; ready outputs are still combinational during reset but accepted ops are discarded.

## Test plan
- Single ADD: req0 a=5, b=7, op=010 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, result=12, zero=0.
- Conflict after reset: both valid, req0 SUB 9-9, req1 OR 0xF0|0x0F, rsp ready=1 -> cycle 1 grant 0 (rsp0 result 0, zero 1), cycle 2 grant 1 (rsp1 result 0xFF); continued conflict alternates 0,1,0,1.
- Back-pressure: rsp0_ready=0 with rsp0 full, req0 and req1 valid -> req0_ready=0, req1 granted every cycle; rsp0 fields unchanged until rsp0_ready=1.
- Drain+refill: rsp0_valid=1, rsp0_ready=1, req0 AND 0xFFFF0000 & 0x0F0F0F0F -> req0 granted; rsp0_valid stays 1, next result=0x0F0F0000.
- Illegal op: req1 op=011 a=3 b=4 -> rsp1 result=0, zero=1.
- Reset mid-stream: assert reset while rsp0/rsp1 valid -> next cycle both rsp valid=0, results 0; first conflict afterwards granted to requester 0.
